// File: rtl/lcd_char_writer_pkg.sv
// Shared constants for the HD44780-style character LCD writer: FSM state
// encodings, controller command bytes and DDRAM line base addresses.
package lcd_char_writer_pkg;

    localparam int PWRUP_TICKS_DEF = 20;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] DDRAM_L1  = 8'h80;
    localparam logic [7:0] DDRAM_L2  = 8'hC0;

    localparam logic [3:0] ST_PWRUP   = 4'd0;
    localparam logic [3:0] ST_FUNC    = 4'd1;
    localparam logic [3:0] ST_DISP    = 4'd2;
    localparam logic [3:0] ST_ENTRY   = 4'd3;
    localparam logic [3:0] ST_CLEAR   = 4'd4;
    localparam logic [3:0] ST_L1_ADDR = 4'd5;
    localparam logic [3:0] ST_L1_DATA = 4'd6;
    localparam logic [3:0] ST_L2_ADDR = 4'd7;
    localparam logic [3:0] ST_L2_DATA = 4'd8;

    // Bus byte driven by each command-type (rs=0) state.
    function automatic logic [7:0] cmd_byte(input logic [3:0] st);
        logic [7:0] b;
        case (st)
            ST_FUNC:    b = CMD_FUNC;
            ST_DISP:    b = CMD_DISP;
            ST_ENTRY:   b = CMD_ENTRY;
            ST_CLEAR:   b = CMD_CLEAR;
            ST_L1_ADDR: b = DDRAM_L1;
            ST_L2_ADDR: b = DDRAM_L2;
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

    // Successor of each single-transaction command state.
    function automatic logic [3:0] cmd_next(input logic [3:0] st);
        logic [3:0] n;
        case (st)
            ST_FUNC:    n = ST_DISP;
            ST_DISP:    n = ST_ENTRY;
            ST_ENTRY:   n = ST_CLEAR;
            ST_CLEAR:   n = ST_L1_ADDR;
            ST_L1_ADDR: n = ST_L1_DATA;
            ST_L2_ADDR: n = ST_L2_DATA;
            default:    n = ST_PWRUP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lcd_char_writer.sv
// 8-bit HD44780-style LCD driver: power-up wait, init commands, then endless
// 2x16 refresh. One bus phase per en_tick; every transaction is E-high then E-low.
module lcd_char_writer
    import lcd_char_writer_pkg::*;
#(
    parameter int PWRUP_TICKS = PWRUP_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tick,
    input  logic [7:0] char_data,
    output logic [4:0] char_addr,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam logic [7:0] PWRUP_LAST = 8'(PWRUP_TICKS - 1);

    logic [3:0] state_r;
    logic       phase_r;
    logic [7:0] tick_cnt_r;
    logic [3:0] col_r;
    logic       line_r;
    logic       lcd_rs_r;
    logic       lcd_e_r;
    logic [7:0] lcd_data_r;
    logic       init_done_r;
    logic       frame_done_r;

    // Sequencer: every state and output register moves only on en_tick, except frame_done clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_PWRUP;
            phase_r      <= 1'b0;
            tick_cnt_r   <= 8'd0;
            col_r        <= 4'd0;
            line_r       <= 1'b0;
            lcd_rs_r     <= 1'b0;
            lcd_e_r      <= 1'b0;
            lcd_data_r   <= 8'h00;
            init_done_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            if (en_tick) begin
                case (state_r)
                    ST_PWRUP: begin
                        if (tick_cnt_r == PWRUP_LAST) begin
                            tick_cnt_r <= 8'd0;
                            state_r    <= ST_FUNC;
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 8'd1;
                        end
                    end
                    ST_FUNC, ST_DISP, ST_ENTRY, ST_CLEAR, ST_L1_ADDR, ST_L2_ADDR: begin
                        if (!phase_r) begin
                            lcd_rs_r   <= 1'b0;
                            lcd_data_r <= cmd_byte(state_r);
                            lcd_e_r    <= 1'b1;
                            phase_r    <= 1'b1;
                        end else begin
                            lcd_e_r  <= 1'b0;
                            phase_r  <= 1'b0;
                            state_r  <= cmd_next(state_r);
                            line_r   <= (state_r == ST_L2_ADDR);
                            if (state_r == ST_CLEAR) begin
                                init_done_r <= 1'b1;
                            end else begin
                                init_done_r <= init_done_r;
                            end
                        end
                    end
                    ST_L1_DATA, ST_L2_DATA: begin
                        if (!phase_r) begin
                            // char_data is only trusted on this tick; phase 1 holds it on the bus
                            lcd_rs_r   <= 1'b1;
                            lcd_data_r <= char_data;
                            lcd_e_r    <= 1'b1;
                            phase_r    <= 1'b1;
                        end else begin
                            lcd_e_r <= 1'b0;
                            phase_r <= 1'b0;
                            if (col_r == 4'd15) begin
                                col_r        <= 4'd0;
                                line_r       <= 1'b0;
                                state_r      <= (state_r == ST_L1_DATA) ? ST_L2_ADDR : ST_L1_ADDR;
                                frame_done_r <= (state_r == ST_L2_DATA);
                            end else begin
                                col_r <= col_r + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_PWRUP;
                        phase_r <= 1'b0;
                        lcd_e_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign char_addr  = {line_r, col_r};
    assign lcd_rs     = lcd_rs_r;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = lcd_e_r;
    assign lcd_data   = lcd_data_r;
    assign init_done  = init_done_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Self-checking bench for lcd_char_writer: a tick-indexed model of the bus
// sequence is compared every clock, plus hand-computed literal checkpoints.
module tb_lcd_char_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_tick = 1'b0;
    logic [7:0] char_data;
    logic [4:0] char_addr;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
    logic [7:0] lcd_data;

    logic junk_mode = 1'b0;
    logic good_slot = 1'b0;
    int   tick_n = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    lcd_char_writer dut (
        .clk(clk), .rst(rst), .en_tick(en_tick), .char_data(char_data),
        .char_addr(char_addr), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Upstream character buffer; in junk mode it is only correct on phase-0 data ticks.
    assign char_data = (!junk_mode || good_slot)
        ? 8'h41 + {4'b0000, char_addr[3:0]} + (char_addr[4] ? 8'h10 : 8'h00)
        : 8'hEE;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at tick %0d: got %0h expected %0h", name, tick_n, act, exp);
        end
    endtask

    // Transaction g (0-based after power-up): 4 init commands, then 34-transaction frames.
    function automatic void txn_info(input int g, output logic rs, output logic [7:0] d,
                                     output logic [4:0] a);
        logic [7:0] cmds [4];
        int h;
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        if (g < 4) begin
            rs = 1'b0; d = cmds[g]; a = 5'd0;
        end else begin
            h = (g - 4) % 34;
            if (h == 0) begin
                rs = 1'b0; d = 8'h80; a = 5'd0;
            end else if (h <= 16) begin
                rs = 1'b1; d = 8'(8'h41 + h - 1); a = {1'b0, 4'(h - 1)};
            end else if (h == 17) begin
                rs = 1'b0; d = 8'hC0; a = 5'd0;
            end else begin
                rs = 1'b1; d = 8'(8'h51 + h - 18); a = {1'b1, 4'(h - 18)};
            end
        end
    endfunction

    function automatic logic is_data_p0(input int n);
        int k;
        int h;
        k = n - 21;
        if (k < 8 || (k % 2) != 0) return 1'b0;
        h = (k / 2 - 4) % 34;
        return (h != 0 && h != 17);
    endfunction

    // Single compare process: expected outputs after tick_n ticks since reset.
    initial begin
        logic t, rs_x, rs_y, e_x, init_x, fd_x;
        logic [7:0] d_x, d_y;
        logic [4:0] a_x, a_y;
        int k;
        forever begin
            @(posedge clk);
            t = en_tick;
            #1;
            if (rst) tick_n = 0;
            else if (t) tick_n++;
            rs_x = 1'b0; d_x = 8'h00; a_x = 5'd0; e_x = 1'b0; init_x = 1'b0; fd_x = 1'b0;
            if (tick_n > 20) begin
                k = tick_n - 21;
                txn_info(k / 2, rs_x, d_x, a_y);
                e_x = ((k % 2) == 0);
                if (e_x) a_x = a_y;
                else txn_info(k / 2 + 1, rs_y, d_y, a_x);
                init_x = (k >= 7);
                fd_x = t && !rst && (k >= 8) && (((k - 8) % 68) == 67);
            end
            chk("lcd_e", int'(lcd_e), int'(e_x));
            chk("lcd_rs", int'(lcd_rs), int'(rs_x));
            chk("lcd_data", int'(lcd_data), int'(d_x));
            chk("char_addr", int'(char_addr), int'(a_x));
            chk("init_done", int'(init_done), int'(init_x));
            chk("frame_done", int'(frame_done), int'(fd_x));
            chk("lcd_rw", int'(lcd_rw), 0);
        end
    end

    task automatic do_ticks(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < gap - 1; j++) begin
                @(negedge clk); en_tick = 1'b0; good_slot = 1'b0;
            end
            @(negedge clk); en_tick = 1'b1; good_slot = is_data_p0(tick_n + 1);
        end
        @(negedge clk); en_tick = 1'b0; good_slot = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_ticks(20, 4);
        chk("pwrup_e_low", int'(lcd_e), 0);
        do_ticks(1, 4);
        chk("func_e", int'(lcd_e), 1);
        chk("func_data", int'(lcd_data), 'h38);
        do_ticks(6, 4);
        chk("init_t27", int'(init_done), 0);
        do_ticks(1, 4);
        chk("init_t28", int'(init_done), 1);
        chk("clear_data", int'(lcd_data), 'h01);
        do_ticks(3, 4);
        chk("first_char", int'(lcd_data), 'h41);
        chk("first_char_rs", int'(lcd_rs), 1);
        do_ticks(64, 4);
        chk("last_char", int'(lcd_data), 'h60);
        do_ticks(1, 4);
        chk("frame_pulse", int'(frame_done), 1);
        do_ticks(1, 4);
        chk("wrap_addr", int'(lcd_data), 'h80);
        chk("wrap_rs", int'(lcd_rs), 0);

        do_ticks(70, 1);
        chk("burst_t167", int'(lcd_data), 'h41);

        junk_mode = 1'b1;
        do_ticks(69, 4);
        chk("hold_p1_data", int'(lcd_data), 'h41);
        junk_mode = 1'b0;

        do_ticks(13, 4);
        chk("col7_e", int'(lcd_e), 1);
        chk("col7_data", int'(lcd_data), 'h48);
        rst = 1'b1;
        #1;
        chk("rst_e", int'(lcd_e), 0);
        chk("rst_data", int'(lcd_data), 0);
        chk("rst_rs", int'(lcd_rs), 0);
        chk("rst_addr", int'(char_addr), 0);
        chk("rst_init", int'(init_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_ticks(20, 4);
        chk("re_pwrup_e", int'(lcd_e), 0);
        do_ticks(1, 4);
        chk("re_func_data", int'(lcd_data), 'h38);
        chk("re_func_e", int'(lcd_e), 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
